mips_mc_ctrl: RTL

Multi-cycle sequencer for the MIPS core. It consumes the op and func fields produced by the instruction field splitter and steps each instruction through fetch, decode, execute, memory and write-back. It drives the enables and mux selects for the PC, IR, register file, ALU and data memory. It also handshakes with instruction/data memory (ready) and the iterative multiply/divide unit (start/done).

---
 rtl/mips_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl - multi-cycle sequencer for the MIPS core.
//
// Moves each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB.
// The instruction class is latched from op/func in DECODE. Outputs are
// combinational from the state and the class. The class used in DECODE
// itself comes straight from the decoder, because the class register is
// only written at the end of that cycle.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : ILLEGAL instructions go DECODE -> TRAP (vector redirect, no retire)
//   undefined : ILLEGAL instructions execute as NOP (retire in EXEC)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op, func            instruction[31:26], instruction[5:0]
//   mem_ready           imem/dmem access completes this cycle
//   md_done             mul/div result valid (1-cycle pulse)
//   br_cond             resolved branch condition
//   imem_req, ir_we     fetch request, instruction register load
//   pc_we, pc_src       PC write and source (0 PC+4, 1 branch, 2 jump, 3 trap)
//   alu_srcb, alu_op    ALU operand B select and function
//   dmem_req, dmem_we   data memory request / write
//   rf_we, rf_wsel      register write, dest select (0 rd, 1 rt, 2 r31)
//   rf_dsel             write data select (0 ALU, 1 mem, 2 link, 3 HI/LO)
//   md_start            mul/div start pulse
//   md_timeout          mul/div wait expired
//   retire              instruction completed
//   state               current state (debug)
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | after reset, always moves to FETCH
// FETCH | instruction fetch, waits for mem_ready
// DECODE| class decode; jumps finish here
// EXEC  | ALU step; branches / NOP finish here
// MEM   | load/store access, waits for mem_ready
// WB    | register file write-back
// MDWAIT| waits for md_done or timeout
// TRAP  | redirect PC to the exception vector

module mips_mc_ctrl #(
    parameter int MD_TIMEOUT   = 64,
    parameter int TRAP_VEC_SEL = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    input  logic       md_done,
    input  logic       br_cond,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_srcb,
    output logic [3:0] alu_op,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic [1:0] rf_wsel,
    output logic [1:0] rf_dsel,
    output logic       md_start,
    output logic       md_timeout,
    output logic       retire,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MDWAIT = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_JR, C_JALR, C_MD, C_IALU, C_LOAD,
        C_STORE, C_BR, C_J, C_JAL, C_ILLEGAL
    } cls_t;

    // ALU function per class; R-type and I-type are refined by the datapath
    // from func/op respectively.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_RFN  = 4'h1;
    localparam logic [3:0] ALU_IFN  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;

    localparam int CW = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CW-1:0] MD_LAST = CW'(MD_TIMEOUT - 1);

    state_t        state_q, state_d;
    cls_t          cls_q, dec_cls;
    logic [CW-1:0] md_cnt;

    always_comb begin
        dec_cls = C_ILLEGAL;
        case (op)
            6'h00: begin
                case (func)
                    6'h08:                      dec_cls = C_JR;
                    6'h09:                      dec_cls = C_JALR;
                    6'h18, 6'h19, 6'h1A, 6'h1B: dec_cls = C_MD;
                    default:                    dec_cls = C_RALU;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:          dec_cls = C_IALU;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:   dec_cls = C_LOAD;
            6'h28, 6'h29, 6'h2B:                 dec_cls = C_STORE;
            6'h01, 6'h04, 6'h05:                 dec_cls = C_BR;
            6'h02:                               dec_cls = C_J;
            6'h03:                               dec_cls = C_JAL;
            default:                             dec_cls = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NOP;
            md_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            // Counts cycles spent in MDWAIT; cleared whenever MDWAIT is left.
            if (state_q == S_MDWAIT && state_d == S_MDWAIT) md_cnt <= md_cnt + CW'(1);
            else                                             md_cnt <= '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_srcb   = 1'b0;
        alu_op     = ALU_ADD;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        rf_wsel    = 2'd0;
        rf_dsel    = 2'd0;
        md_start   = 1'b0;
        md_timeout = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (dec_cls)
                    C_J, C_JR, C_JAL, C_JALR: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                        if (dec_cls == C_JAL || dec_cls == C_JALR) begin
                            rf_we   = 1'b1;
                            rf_dsel = 2'd2;
                            rf_wsel = (dec_cls == C_JAL) ? 2'd2 : 2'd0;
                        end
                    end
`ifdef MC_ILLEGAL_TRAP_EN
                    C_ILLEGAL: state_d = S_TRAP;
`endif
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_RALU: begin
                        alu_op  = ALU_RFN;
                        state_d = S_WB;
                    end
                    C_IALU: begin
                        alu_op   = ALU_IFN;
                        alu_srcb = 1'b1;
                        state_d  = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_srcb = 1'b1;
                        state_d  = S_MEM;
                    end
                    C_BR: begin
                        alu_op  = ALU_SUB;
                        pc_we   = br_cond;
                        pc_src  = 2'd1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_MD: begin
                        md_start = 1'b1;
                        state_d  = S_MDWAIT;
                    end
                    default: begin
                        // NOP, and ILLEGAL when trapping is not built in
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                rf_wsel = (cls_q == C_RALU) ? 2'd0 : 2'd1;
                rf_dsel = (cls_q == C_LOAD) ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_MDWAIT: begin
                // md_done takes priority over an expiring timeout
                if (md_done) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (md_cnt == MD_LAST) begin
                    md_timeout = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_TRAP: begin
                pc_we   = 1'b1;
                pc_src  = 2'(TRAP_VEC_SEL);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule
